// File: rtl/ma_load_store_unit.sv
// Memory-access load/store unit for a word-addressed data memory.
// Sub-word loads extract and extend; sub-word stores use read-modify-write.
module ma_load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        mem_write
);

  typedef enum logic [2:0] {
    IDLE, LD, RMW_RD, WR_SETUP, WR_STROBE, RESP
  } state_t;

  state_t      state, state_n;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;
  logic        fault_q;

  logic        accept;
  logic        is_half, is_word;
  logic        bad_f3, misal, oor, bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val, merged;

  assign busy = (state != IDLE);

  always_comb begin
    accept  = (state == IDLE) && req_valid && (req_read ^ req_write);
    is_half = (funct3[1:0] == 2'd1);
    is_word = (funct3[1:0] == 2'd2);
    bad_f3  = req_read ? (funct3 == 3'd3 || funct3[2:1] == 2'b11)
                       : (funct3 >= 3'd3);
    misal   = (is_half && addr[0]) || (is_word && addr[1:0] != 2'd0);
    oor     = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
    bad     = bad_f3 || misal || oor;
  end

  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val = '0;
    unique case (1'b1)
      f3_q == 3'd0: ld_val = {{24{lane_b[7]}}, lane_b};
      f3_q == 3'd1: ld_val = {{16{lane_h[15]}}, lane_h};
      f3_q == 3'd2: ld_val = mem_rdata;
      f3_q == 3'd4: ld_val = {24'd0, lane_b};
      f3_q == 3'd5: ld_val = {16'd0, lane_h};
      default:      ld_val = '0;
    endcase
  end

  // Untouched bytes come from the word just read.
  always_comb begin
    merged = mem_rdata;
    if (f3_q[1:0] == 2'd0)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (off_q[1])
      merged[31:16] = wdata_q[15:0];
    else
      merged[15:0] = wdata_q[15:0];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)
            state_n = RESP;
          else if (req_read)
            state_n = LD;
          else if (funct3 == 3'd2)
            state_n = WR_SETUP;
          else
            state_n = RMW_RD;
        end
      end
      LD:        state_n = RESP;
      RMW_RD:    state_n = WR_SETUP;
      WR_SETUP:  state_n = WR_STROBE;
      WR_STROBE: state_n = RESP;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      rdata      <= '0;
      fault      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      mem_read   <= (state_n == LD) || (state_n == RMW_RD);
      mem_write  <= (state_n == WR_STROBE);
      resp_valid <= (state == RESP);
      fault      <= (state == RESP) && fault_q;
      rdata      <= (state == RESP && !fault_q) ? result_q : '0;
      if (accept) begin
        f3_q     <= funct3;
        off_q    <= addr[1:0];
        wdata_q  <= wdata;
        fault_q  <= bad;
        result_q <= '0;
        if (!bad) begin
          mem_addr <= {2'b00, addr[31:2]};
          if (req_write && funct3 == 3'd2)
            mem_wdata <= wdata;
        end
      end
      if (state == LD)
        result_q <= ld_val;
      if (state == RMW_RD)
        mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_ma_load_store_unit.sv
// Directed bench for ma_load_store_unit with a small word memory model.
// Checks latency, load extension, RMW merge, faults, reset abort.
module tb_ma_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, resp_valid, fault;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:1023];
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cyc = 0;
  int both_cnt = 0;
  int resp_cnt = 0;

  always #5 clk = ~clk;

  ma_load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .busy(busy), .resp_valid(resp_valid),
    .rdata(rdata), .fault(fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_write(mem_write)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[9:0]] : 32'd0;

  always @(posedge mem_write) begin
    mem[mem_addr[9:0]] <= mem_wdata;
    wr_cnt <= wr_cnt + 1;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cyc <= rd_cyc + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic rd,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_rd, input logic exp_flt,
                         input int exp_wr, input int exp_rdc);
    int lat;
    int wr0, rd0;
    @(negedge clk);
    wr0 = wr_cnt;
    rd0 = rd_cyc;
    req_valid = 1'b1;
    req_read  = rd;
    req_write = ~rd;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'h5555_5555;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rdata, exp_rd);
    check({tag, ".fault"}, 32'(fault), 32'(exp_flt));
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".wr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, ".rdcyc"}, 32'(rd_cyc - rd0), 32'(exp_rdc));
  endtask

  initial begin
    int r0, w0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5] = 32'h80FF7F01;
    reset = 1'b1;
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    funct3 = 3'd0;
    addr = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.resp", 32'(resp_valid), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.maddr", mem_addr, 32'd0);
    check("rst.mwdata", mem_wdata, 32'd0);
    check("rst.mrd", 32'(mem_read), 32'd0);
    check("rst.mwr", 32'(mem_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_req("lb15", 1, 3'd0, 32'h15, 0, 2, 32'h0000007F, 0, 0, 1);
    run_req("lb17", 1, 3'd0, 32'h17, 0, 2, 32'hFFFFFF80, 0, 0, 1);
    run_req("lbu17", 1, 3'd4, 32'h17, 0, 2, 32'h00000080, 0, 0, 1);
    run_req("lh16", 1, 3'd1, 32'h16, 0, 2, 32'hFFFF80FF, 0, 0, 1);
    run_req("lhu16", 1, 3'd5, 32'h16, 0, 2, 32'h000080FF, 0, 0, 1);
    run_req("lw14", 1, 3'd2, 32'h14, 0, 2, 32'h80FF7F01, 0, 0, 1);

    run_req("sb15", 0, 3'd0, 32'h15, 32'hAA, 4, 0, 0, 1, 1);
    check("sb15.mwdata", mem_wdata, 32'h80FFAA01);
    check("sb15.mem", mem[5], 32'h80FFAA01);
    run_req("sh16", 0, 3'd1, 32'h16, 32'h1234, 4, 0, 0, 1, 1);
    check("sh16.mem", mem[5], 32'h1234AA01);

    run_req("sw20", 0, 3'd2, 32'h20, 32'hDEADBEEF, 3, 0, 0, 1, 0);
    check("sw20.maddr", mem_addr, 32'd8);
    check("sw20.mem", mem[8], 32'hDEADBEEF);

    run_req("f_lw22", 1, 3'd2, 32'h22, 0, 1, 0, 1, 0, 0);
    run_req("f_sh13", 0, 3'd1, 32'h13, 32'h7777, 1, 0, 1, 0, 0);
    run_req("f_f3", 1, 3'd3, 32'h14, 0, 1, 0, 1, 0, 0);
    run_req("f_oor", 1, 3'd2, 32'h1000, 0, 1, 0, 1, 0, 0);
    check("f.mem5", mem[5], 32'h1234AA01);

    // Request presented while busy must be dropped.
    @(negedge clk);
    r0 = resp_cnt;
    w0 = wr_cnt;
    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    funct3 = 3'd2;
    addr = 32'h14;
    @(posedge clk);
    #1;
    req_read = 1'b0;
    req_write = 1'b1;
    addr = 32'h20;
    wdata = 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("busy.lw", rdata, 32'h1234AA01);
    repeat (6) @(posedge clk);
    #1;
    check("busy.resps", 32'(resp_cnt - r0), 32'd1);
    check("busy.wr", 32'(wr_cnt - w0), 32'd0);
    check("busy.mem8", mem[8], 32'hDEADBEEF);

    // Reset while strobing; byte value matches memory so word is unchanged.
    @(negedge clk);
    r0 = resp_cnt;
    w0 = wr_cnt;
    req_valid = 1'b1;
    req_read = 1'b0;
    req_write = 1'b1;
    funct3 = 3'd0;
    addr = 32'h15;
    wdata = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstw.strobe", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstw.mwr", 32'(mem_write), 32'd0);
    check("rstw.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rstw.resps", 32'(resp_cnt - r0), 32'd0);
    check("rstw.wr", 32'(wr_cnt - w0), 32'd1);
    check("rstw.mem", mem[5], 32'h1234AA01);
    check("both_hi", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
